// File: rtl/fp_pkg.sv
// Shared single-precision field definitions for the floating-point divider.
// Holds field widths, the packed float layout, the state encoding and field slice helpers.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int BIAS   = 127;
  localparam int QBITS  = MANT_W + 1;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [FRAC_W-1:0] fp_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division iteration: compare, conditionally subtract, shift,
// and append the new quotient bit.
module fp_div_step
  import fp_pkg::*;
(
  input  logic [MANT_W:0]   rem,
  input  logic [MANT_W-1:0] q,
  input  logic [MANT_W-1:0] mb,
  output logic [MANT_W:0]   rem_next,
  output logic [MANT_W:0]   q_next
);

  logic [MANT_W-1:0] diff_s;

  // Remainder stays below 2*mb, so the difference always fits in MANT_W bits.
  always_comb begin
    diff_s = rem[MANT_W-1:0] - mb;
    if (rem >= {1'b0, mb}) begin
      rem_next = {diff_s, 1'b0};
      q_next   = {q, 1'b1};
    end else begin
      rem_next = {rem[MANT_W-1:0], 1'b0};
      q_next   = {q, 1'b0};
    end
  end

endmodule

// File: rtl/fp_divider.sv
// Multi-cycle single-precision divider: restoring division, one quotient bit per
// clock, truncating normalisation and wrapping 8-bit exponent arithmetic.
module fp_divider
  import fp_pkg::*;
#(
  parameter int BIAS  = 127,
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  div_state_t        state_r, state_n;
  logic [4:0]        cnt_r, cnt_n;
  logic [MANT_W:0]   rem_r, rem_n;
  logic [MANT_W-1:0] q_r, q_n;
  logic [MANT_W-1:0] mb_r, mb_n;
  logic [EXP_W-1:0]  eq_r, eq_n;
  logic              sign_r, sign_n;
  logic [31:0]       result_r, result_n;
  logic              in_ready_r, in_ready_n;
  logic              out_valid_r, out_valid_n;

  logic [MANT_W:0]   step_rem_s;
  logic [MANT_W:0]   step_q_s;
  logic              sign_in_s;

  fp_div_step u_step (
    .rem      (rem_r),
    .q        (q_r),
    .mb       (mb_r),
    .rem_next (step_rem_s),
    .q_next   (step_q_s)
  );

  assign sign_in_s = fp_sign(a) ^ fp_sign(b);

  function automatic logic [31:0] normalise(input logic s, input logic [EXP_W-1:0] e,
                                            input logic [MANT_W:0] qq);
    fp32_t f;
    f.sign = s;
    if (qq[MANT_W]) begin
      f.exp  = e;
      f.frac = qq[MANT_W-1:1];
    end else begin
      f.exp  = e - 8'd1;
      f.frac = qq[FRAC_W-1:0];
    end
    return f;
  endfunction

  // Next-state, datapath and output-register values.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    rem_n       = rem_r;
    q_n         = q_r;
    mb_n        = mb_r;
    eq_n        = eq_r;
    sign_n      = sign_r;
    result_n    = result_r;
    in_ready_n  = in_ready_r;
    out_valid_n = out_valid_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          sign_n     = sign_in_s;
          mb_n       = {1'b1, fp_frac(b)};
          eq_n       = fp_exp(a) - fp_exp(b) + 8'(BIAS);
          in_ready_n = 1'b0;
          if (fp_exp(b) == 8'h00) begin
            result_n    = {sign_in_s, 8'hFF, 23'h0};
            out_valid_n = 1'b1;
            state_n     = DONE;
          end else if (fp_exp(a) == 8'h00) begin
            result_n    = {sign_in_s, 31'h0};
            out_valid_n = 1'b1;
            state_n     = DONE;
          end else begin
            rem_n   = {2'b01, fp_frac(a)};
            q_n     = '0;
            cnt_n   = 5'd0;
            state_n = DIV;
          end
        end else begin
          in_ready_n = 1'b1;
        end
      end
      DIV: begin
        rem_n = step_rem_s;
        q_n   = step_q_s[MANT_W-1:0];
        cnt_n = cnt_r + 5'd1;
        if (cnt_r == 5'(QBITS - 1)) begin
          result_n    = normalise(sign_r, eq_r, step_q_s);
          out_valid_n = 1'b1;
          state_n     = DONE;
        end else begin
          state_n = DIV;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = IDLE;
        end else begin
          out_valid_n = 1'b1;
        end
      end
      default: begin
        state_n     = IDLE;
        in_ready_n  = 1'b1;
        out_valid_n = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 5'd0;
      rem_r       <= '0;
      q_r         <= '0;
      mb_r        <= '0;
      eq_r        <= 8'h00;
      sign_r      <= 1'b0;
      result_r    <= 32'h0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      rem_r       <= rem_n;
      q_r         <= q_n;
      mb_r        <= mb_n;
      eq_r        <= eq_n;
      sign_r      <= sign_n;
      result_r    <= result_n;
      in_ready_r  <= in_ready_n;
      out_valid_r <= out_valid_n;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_fp_divider.sv
// Directed bench for fp_divider: vector table with latency checks plus
// backpressure, mid-operation reset and back-to-back sequences.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;

  fp_divider dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Waits for in_ready at a negedge; the following posedge is the accept edge.
  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Counts negedges after an accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vres, input int vlat);
    int lat;
    @(negedge clk);
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    wait_ready(name);
    @(posedge clk);
    wait_out(lat);
    in_valid = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'(vlat));
    check({name, "_result"}, result, vres);
    @(negedge clk);
    check({name, "_valid_pulse"}, 32'(out_valid), 32'd0);
    check({name, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int gap;
    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 26}; // 6 / 2
    vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26}; // 1 / 3 truncated
    vecs[2] = '{32'hC0F00000, 32'h40200000, 32'hC0400000, 26}; // -7.5 / 2.5
    vecs[3] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1};  // divide by zero
    vecs[4] = '{32'h00000000, 32'h40A00000, 32'h00000000, 1};  // zero dividend
    vecs[5] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1};  // -1 / 0
    vecs[6] = '{32'hBF800000, 32'hC0800000, 32'h3E800000, 26}; // -1 / -4
    vecs[7] = '{32'h40400000, 32'h40000000, 32'h3FC00000, 26}; // 3 / 2
    vecs[8] = '{32'h00800000, 32'h7F000000, 32'h41000000, 26}; // exponent wraps upward
    vecs[9] = '{32'h00800000, 32'h40400000, 32'h7FAAAAAA, 26}; // eq-1 wraps to 0xFF

    rst = 1'b1; a = 32'h0; b = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // Backpressure: result held while out_ready is low, new operands ignored.
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1; out_ready = 1'b0;
    wait_ready("bp");
    @(posedge clk);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd26);
    a = 32'h3F800000; b = 32'h00000000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_result_held", result, 32'h40400000);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a division discards it.
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    wait_ready("rst_mid");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", result, 32'h0);
    run_op("after_rst", 32'h3F800000, 32'h3F800000, 32'h3F800000, 26);

    // Back-to-back: in_valid held high across two operations.
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1; out_ready = 1'b1;
    wait_ready("b2b");
    @(posedge clk);
    @(negedge clk);
    a = 32'hC0F00000; b = 32'h40200000;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", 32'(lat), 32'd26);
    check("b2b_first_result", result, 32'h40400000);
    @(posedge clk);
    gap = 0;
    @(negedge clk);
    gap++;
    while (!in_ready && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_accept_gap", 32'(gap), 32'd1);
    @(posedge clk);
    wait_out(lat);
    in_valid = 1'b0;
    check("b2b_second_latency", 32'(lat), 32'd26);
    check("b2b_second_result", result, 32'hC0400000);
    @(negedge clk);
    check("b2b_done", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
